// File: rtl/uart_pkg.sv
// uart_pkg: shared UART configuration and receive FSM state encoding.
// The default frame constants here are shared by the receiver, the
// transmitter and the baud generator so they agree on the frame format.
package uart_pkg;

  // Default frame format: 8 data bits, 1 stop bit, 16x oversampling.
  localparam int UART_DBIT    = 8;
  localparam int UART_OVS     = 16;
  localparam int UART_SB_TICK = 16;

  // Receive sequencer states. PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Larger of two integers, used to size the shared tick counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single asynchronous bit.
// Both flops load RESET_VAL on synchronous reset so the output does not
// show a spurious edge when reset is released.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  // NOTE: non-blocking assignments make both flops sample their inputs from
  // before the edge, so the value shifts one stage per clock; with blocking
  // assignments i_d would fall straight through to r_sync in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driven by a 16x oversampling tick.
// Detects the start bit, samples each data bit at mid-bit (LSB first),
// samples the stop bit on the final stop-phase tick and presents the byte
// with a one-cycle rx_done_tick.
// Optional even-parity checking is built in when UART_RX_PARITY_EN is
// defined; otherwise parity_err is tied low and no PARITY phase exists.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int OVS     = UART_OVS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err
);

  // The tick counter serves every phase, so it must reach both the bit
  // length and the stop-phase length.
  localparam int S_W = $clog2(max_int(OVS, SB_TICK));
  localparam int N_W = $clog2(DBIT);

  localparam logic [S_W-1:0] S_HALF = S_W'(OVS / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  logic            w_rx_s;

  rx_state_e       r_state;
  rx_state_e       w_state_nxt;
  logic [S_W-1:0]  r_s;
  logic [S_W-1:0]  w_s_nxt;
  logic [N_W-1:0]  r_n;
  logic [N_W-1:0]  w_n_nxt;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] w_b_nxt;
  logic [DBIT-1:0] r_dout;
  logic [DBIT-1:0] w_dout_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_frame_err;
  logic            w_frame_err_nxt;

`ifdef UART_RX_PARITY_EN
  logic            r_par_bit;
  logic            w_par_bit_nxt;
  logic            r_parity_err;
  logic            w_parity_err_nxt;
`endif

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

  // Next-state, counter, shift-register and output-register decode.
  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_s_nxt         = r_s;
    w_n_nxt         = r_n;
    w_b_nxt         = r_b;
    w_dout_nxt      = r_dout;
    w_done_nxt      = 1'b0;
    w_frame_err_nxt = r_frame_err;
`ifdef UART_RX_PARITY_EN
    w_par_bit_nxt    = r_par_bit;
    w_parity_err_nxt = r_parity_err;
`endif

    unique case (r_state)
      IDLE: begin
        // A low line starts a frame immediately; no tick needed.
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_nxt     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (r_s == S_HALF) begin
            // Mid start bit: still low means a real start, else a glitch.
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_nxt = r_s + S_W'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (r_s == S_BIT) begin
            w_s_nxt = '0;
            w_b_nxt = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end else begin
              w_n_nxt = r_n + N_W'(1);
            end
          end else begin
            w_s_nxt = r_s + S_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_s == S_BIT) begin
            w_s_nxt       = '0;
            w_par_bit_nxt = w_rx_s;
            w_state_nxt   = STOP;
          end else begin
            w_s_nxt = r_s + S_W'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (r_s == S_STOP) begin
            // Frame complete: publish the byte and its status together.
            w_dout_nxt      = r_b;
            w_frame_err_nxt = ~w_rx_s;
            w_done_nxt      = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_parity_err_nxt = (^r_b) ^ r_par_bit;
`endif
            w_state_nxt     = IDLE;
          end else begin
            w_s_nxt = r_s + S_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s         <= w_s_nxt;
      r_n         <= w_n_nxt;
      r_b         <= w_b_nxt;
      r_dout      <= w_dout_nxt;
      r_done      <= w_done_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Latched parity bit and the parity status of the last frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bit    <= w_par_bit_nxt;
      r_parity_err <= w_parity_err_nxt;
    end
  end

  assign parity_err = r_parity_err;
`else
  // Port kept so the interface is identical with and without parity.
  assign parity_err = 1'b0;
`endif

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
  assign frame_err    = r_frame_err;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART path.
- Consumes the oversampling tick from the mod-M baud generator, which runs at 16x baud.
- Detects the start bit, samples data bits at mid-bit, and checks the stop bit.
- Delivers each received byte with a one-cycle done pulse to the downstream interface/FIFO.

Parameters:
- DBIT, 8: data bits per frame, LSB first. Legal range 5..8.
- SB_TICK, 16: s_tick count for the stop phase. 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- OVS, 16: oversampling ratio, i.e. s_ticks per bit. Must be even.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- s_tick  in  1  one-clk-wide oversampling strobe from the baud generator.
- rx_done_tick  out  1  one-cycle pulse; dout/frame_err valid from this cycle on.
- dout  out  DBIT  last received data word.
- frame_err  out  1  stop bit sampled low on the last frame.
- parity_err  out  1  parity mismatch on the last frame (PARITY_EN only; tied 0 otherwise).

Behaviour:
- Clock and reset:
  - One clock: clk.
  - reset is synchronous and active-high. All state updates only on posedge clk; reset is sampled there.
- rx synchronizer:
  - rx passes through a 2-FF synchronizer; both flops reset to 1.
  - All references to rx below mean the synchronized value, rx_s.
  - Edge-to-FSM latency is 2 clk.
- Counters:
  - s: tick counter, width clog2(max(OVS, SB_TICK)).
  - n: bit counter, width clog2(DBIT).
  - b: shift register, DBIT wide.
- The FSM advances only on cycles with s_tick=1. Without a tick, all state, s, n and b hold.
- State IDLE:
  - rx_s==0 → START, s←0. No tick is required.
- State START, on tick:
  - If s==OVS/2-1: if rx_s==0 → DATA, s←0, n←0. Else (glitch/false start) → IDLE.
  - Otherwise s←s+1.
- State DATA, on tick:
  - If s==OVS-1: s←0, b←{rx_s, b[DBIT-1:1]}.
  - Then if n==DBIT-1 → PARITY (if enabled) else STOP. Otherwise n←n+1.
  - Otherwise s←s+1.
- State STOP, on tick:
  - If s==SB_TICK-1: registered update next edge: dout←b, frame_err←~rx_s, rx_done_tick←1; → IDLE.
  - Otherwise s←s+1.
  - The stop bit is sampled at the final tick of the stop phase.
- Output timing:
  - rx_done_tick is high for exactly one clk, the cycle after the completing s_tick edge.
  - dout, frame_err and parity_err hold until the next completed frame.
  - A false start does not update any output.
- Frame errors:
  - A frame with a bad stop bit still produces rx_done_tick and updates dout; frame_err=1.
  - After a low stop bit, IDLE sees rx_s==0 and immediately enters START. This is the required behaviour: a break resyncs naturally.
- Reset values:
  - state=IDLE, s=0, n=0, b=0, dout=0, rx_done_tick=0, frame_err=0, parity_err=0, synchronizer=1.
- Reset mid-frame aborts the frame with no done pulse. Reception resumes with the next falling edge after reset deasserts.
- Back-to-back frames: IDLE→START takes one clk, so zero idle bits between stop and the next start is supported.
- Back-to-back tick cycles (s_tick held high) are legal. Each high cycle counts as one tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds state PARITY between DATA and STOP.
  - On tick with s==OVS-1: s←0; the parity bit is latched; → STOP.
  - Even parity: parity_err←(^b)^parity_bit, registered together with dout at frame completion.
- When undefined:
  - No PARITY state; DATA goes directly to STOP.
  - parity_err is tied to 0, and the port remains so the interface is stable.

Decomposition:
- Package uart_pkg:
  - State encoding constants IDLE/START/DATA/PARITY/STOP (3-bit).
  - Default OVS=16, DBIT=8 and SB_TICK constants shared with uart_tx and the baud generator configuration.
- One sub-module: sync_2ff. Generic 2-flop synchronizer with parameter RESET_VAL, instantiated with RESET_VAL=1 for rx.

Test Plan:
- Frame 0xA5, 8N1, s_tick every 4 clk → one rx_done_tick; dout=0xA5, frame_err=0, parity_err=0.
- rx low for only 5 ticks then high (glitch) → return to IDLE; no rx_done_tick; dout keeps the previous value.
- Frame 0x3C with stop bit driven 0 → rx_done_tick; dout=0x3C, frame_err=1. A following valid frame 0x81 → frame_err=0, dout=0x81.
- reset asserted for 1 clk during data bit 4 of 0xFF → no done pulse; outputs 0. The next frame 0x12 is received correctly.
- Back-to-back frames 0x00 then 0xFF with no idle gap, s_tick tied high → two done pulses exactly 160 clk apart (10 bits × 16 ticks); dout values correct.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 → parity_err=0; 0x07 with parity bit 0 → parity_err=1.
